alu_mc: RTL and testbench



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv.sv | 136 +++++++++++++
 rtl/alu_mc.sv | 77 +++++++
 tb/tb_alu_mc.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, multiply/divide FSM states and the signed-overflow helper for alu_mc.
package alu_pkg;

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_ADDU  = 5'b00011;
    localparam logic [4:0] OP_SLTU  = 5'b00101;
    localparam logic [4:0] OP_SUB   = 5'b00110;
    localparam logic [4:0] OP_SLT   = 5'b00111;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SRL   = 5'b01001;
    localparam logic [4:0] OP_SRA   = 5'b01010;
    localparam logic [4:0] OP_XOR   = 5'b01100;
    localparam logic [4:0] OP_NOR   = 5'b01101;
    localparam logic [4:0] OP_SUBU  = 5'b01110;
    localparam logic [4:0] OP_LUI   = 5'b01111;
    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTHI  = 5'b11000;
    localparam logic [4:0] OP_MTLO  = 5'b11001;

    typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

    // Sign bits of a, b and the result; for subtract the effective b sign is inverted.
    function automatic logic f_ovf(input logic a_s, input logic b_s, input logic r_s, input logic sub);
        f_ovf = (a_s == (b_s ^ sub)) && (r_s != a_s);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Divider datapath is built only when ALU_DIV_EN is defined.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    md_state_t          r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_fix_ph;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_d;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_is_md;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [2*WIDTH-1:0] w_fix;

`ifdef ALU_DIV_EN
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;

    assign w_is_md    = (i_op == OP_MULT) || (i_op == OP_MULTU) || (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_rem_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_d};
    assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
`else
    assign w_is_md    = (i_op == OP_MULT) || (i_op == OP_MULTU);
    assign w_div_next = r_p;
`endif

    // Signed ops (even opcodes) work on magnitudes; the sign is restored in FIX.
    assign w_sa    = ~i_op[0] & i_a[WIDTH-1];
    assign w_sb    = ~i_op[0] & i_b[WIDTH-1];
    assign w_mag_a = w_sa ? -i_a : i_a;
    assign w_mag_b = w_sb ? -i_b : i_b;

    assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_d} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

    assign w_q   = r_p[WIDTH-1:0];
    assign w_r   = r_p[2*WIDTH-1:WIDTH];
    assign w_fix = r_is_div ? {(r_neg_r ? -w_r : w_r), (r_neg_q ? -w_q : w_q)}
                            : (r_neg_q ? -r_p : r_p);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_fix_ph <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_d      <= '0;
            r_p      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && w_is_md) begin
                        r_is_div <= i_op[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_d      <= i_op[1] ? w_mag_b : w_mag_a;
                        r_p      <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag_a : w_mag_b)};
                        r_cnt    <= CW'(WIDTH - 1);
                        r_state  <= RUN;
                    end else if (i_start && i_op == OP_MTHI) begin
                        r_hi <= i_a;
                    end else if (i_start && i_op == OP_MTLO) begin
                        r_lo <= i_a;
                    end
                end
                RUN: begin
                    r_p <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt == '0) begin
                        r_state  <= FIX;
                        r_fix_ph <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    // First FIX cycle corrects signs, second commits to HI/LO.
                    if (!r_fix_ph) begin
                        r_p      <= w_fix;
                        r_fix_ph <= 1'b1;
                    end else begin
                        r_hi     <= r_p[2*WIDTH-1:WIDTH];
                        r_lo     <= r_p[WIDTH-1:0];
                        r_done   <= 1'b1;
                        r_fix_ph <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_mc.sv
// EX-stage ALU: combinational single-cycle ops plus the alu_muldiv HI/LO unit.
// Define ALU_DIV_EN to build DIV/DIVU support.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             START,
    output logic [WIDTH-1:0] Y,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_y;
    logic             w_ovf;

    assign w_sum = A + B;
    assign w_dif = A - B;
    assign w_sh  = B[SHW-1:0];

    always_comb begin
        w_y   = '0;
        w_ovf = 1'b0;
        case (OP)
            OP_AND:  w_y = A & B;
            OP_OR:   w_y = A | B;
            OP_XOR:  w_y = A ^ B;
            OP_NOR:  w_y = ~(A | B);
            OP_ADD:  begin
                w_y   = w_sum;
                w_ovf = f_ovf(A[WIDTH-1], B[WIDTH-1], w_sum[WIDTH-1], 1'b0);
            end
            OP_SUB:  begin
                w_y   = w_dif;
                w_ovf = f_ovf(A[WIDTH-1], B[WIDTH-1], w_dif[WIDTH-1], 1'b1);
            end
            OP_ADDU: w_y = w_sum;
            OP_SUBU: w_y = w_dif;
            OP_SLT:  w_y = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: w_y = WIDTH'(A < B);
            OP_SLL:  w_y = A << w_sh;
            OP_SRL:  w_y = A >> w_sh;
            OP_SRA:  w_y = WIDTH'($signed(A) >>> w_sh);
            OP_LUI:  w_y = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: w_y = '0;
        endcase
    end

    assign Y   = w_y;
    assign OVF = w_ovf;

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_op    (OP),
        .i_a     (A),
        .i_b     (B),
        .i_start (START),
        .o_busy  (BUSY),
        .o_done  (DONE),
        .o_hi    (HI),
        .o_lo    (LO)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32) against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [4:0]    OP  = 5'b0;
    logic [W-1:0]  A   = '0;
    logic [W-1:0]  B   = '0;
    logic          START = 1'b0;
    logic [W-1:0]  Y, HI, LO;
    logic          OVF, BUSY, DONE;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_mc #(.WIDTH(W), .SHW(5)) dut (
        .CLK(CLK), .RST(RST), .OP(OP), .A(A), .B(B), .START(START),
        .Y(Y), .OVF(OVF), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    // Reference single-cycle result: {ovf, y}
    function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] y;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        y  = 32'h0;
        ov = 1'b0;
        case (op)
            5'b00000: y = a & b;
            5'b00001: y = a | b;
            5'b01100: y = a ^ b;
            5'b01101: y = ~(a | b);
            5'b00010: begin s = sa + sb; y = a + b; ov = (s > SMAX) || (s < SMIN); end
            5'b00110: begin s = sa - sb; y = a - b; ov = (s > SMAX) || (s < SMIN); end
            5'b00011: y = a + b;
            5'b01110: y = a - b;
            5'b00111: y = (sa < sb) ? 32'd1 : 32'd0;
            5'b00101: y = (a < b) ? 32'd1 : 32'd0;
            5'b01000: y = a << b[4:0];
            5'b01001: y = a >> b[4:0];
            5'b01010: y = 32'(sa >>> b[4:0]);
            5'b01111: y = {b[15:0], 16'h0};
            default:  y = 32'h0;
        endcase
        return {ov, y};
    endfunction

    // Reference mult/div result: {HI, LO}
    function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'b10000: return 64'(sa * sb);
            5'b10001: return {32'h0, a} * {32'h0, b};
            5'b10010: begin
                if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Present a START for one edge; returns at the negedge after that edge.
    task automatic md_issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        OP = op; A = a; B = b; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Count negedges with BUSY high; returns on the first non-busy negedge.
    task automatic md_wait(output int cyc, output logic dn);
        cyc = 0;
        while (BUSY === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge CLK);
        end
        dn = DONE;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; OP = 5'b11000; A = 32'h55; START = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", BUSY, DONE, HI, LO);
        end
    endtask

    task automatic test_single();
        logic [4:0] codes [19];
        logic [32:0] e;
        codes = '{5'b00000, 5'b00001, 5'b01100, 5'b01101, 5'b00010, 5'b00110, 5'b00011,
                  5'b01110, 5'b00111, 5'b00101, 5'b01000, 5'b01001, 5'b01010, 5'b01111,
                  5'b00100, 5'b01011, 5'b10000, 5'b10010, 5'b11111};
        // Directed cases: {op, a, b, expected ovf, expected y}
        begin
            logic [4:0]  dop [7];
            logic [31:0] da [7], db [7], dy [7];
            logic        dv [7];
            dop = '{5'b00111, 5'b00101, 5'b00010, 5'b00011, 5'b01010, 5'b01001, 5'b01111};
            da  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0};
            db  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h4, 32'h4, 32'h1234};
            dy  = '{32'h1, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'hF800_0000, 32'h0800_0000, 32'h1234_0000};
            dv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < 7; i++) begin
                OP = dop[i]; A = da[i]; B = db[i];
                #1;
                n_cmp++;
                if (Y !== dy[i] || OVF !== dv[i]) begin
                    n_fail++;
                    $display("FAIL directed[%0d] op=%b: y=%h ovf=%b, required y=%h ovf=%b", i, dop[i], Y, OVF, dy[i], dv[i]);
                end
            end
        end
        for (int i = 0; i < 80; i++) begin
            OP = codes[$urandom_range(0, 18)];
            A  = $urandom;
            B  = (i % 4 == 0) ? A ^ 32'h8000_0000 : $urandom;
            #1;
            e = ref_alu(OP, A, B);
            n_cmp++;
            if (Y !== e[31:0] || OVF !== e[32]) begin
                n_fail++;
                $display("FAIL random_alu op=%b a=%h b=%h: y=%h ovf=%b, required y=%h ovf=%b", OP, A, B, Y, OVF, e[31:0], e[32]);
            end
        end
    endtask

    task automatic test_mult();
        int c, c0;
        logic dn;
        logic [63:0] e;
        @(negedge CLK);
        md_issue(5'b10001, 32'hFFFF_FFFF, 32'h2);
        md_wait(c, dn);
        n_cmp++;
        if (c != 34 || dn !== 1'b1 || HI !== 32'h1 || LO !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL multu: cyc=%0d done=%b hi=%h lo=%h, required 34 1 00000001 fffffffe", c, dn, HI, LO);
        end
        @(negedge CLK);
        n_cmp++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", DONE);
        end
        // MULT -3*7 with a MULTU START injected mid-run that must be ignored
        md_issue(5'b10000, 32'hFFFF_FFFD, 32'h7);
        c0 = 0;
        repeat (5) begin
            if (BUSY === 1'b1) c0++;
            @(negedge CLK);
        end
        if (BUSY === 1'b1) c0++;
        md_issue(5'b10001, 32'h1234_5678, 32'h9);
        md_wait(c, dn);
        n_cmp++;
        if (c + c0 != 34 || dn !== 1'b1 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_ignore_start: cyc=%0d done=%b hi=%h lo=%h, required 34 1 ffffffff ffffffeb", c + c0, dn, HI, LO);
        end
        for (int i = 0; i < 6; i++) begin
            logic [4:0] op;
            logic [31:0] a, b;
            op = (i % 2 == 0) ? 5'b10000 : 5'b10001;
            a = $urandom;
            b = (i == 4) ? 32'h8000_0000 : $urandom;
            @(negedge CLK);
            md_issue(op, a, b);
            md_wait(c, dn);
            e = ref_md(op, a, b);
            n_cmp++;
            if (c != 34 || dn !== 1'b1 || {HI, LO} !== e) begin
                n_fail++;
                $display("FAIL random_mult op=%b a=%h b=%h: cyc=%0d hi=%h lo=%h, required 34 hi=%h lo=%h", op, a, b, c, HI, LO, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_div();
        int c;
        logic dn;
`ifdef ALU_DIV_EN
        logic [4:0]  dop [4];
        logic [31:0] da [4], db [4];
        logic [63:0] e;
        dop = '{5'b10010, 5'b10011, 5'b10010, 5'b10010};
        da  = '{32'hFFFF_FFF9, 32'h5, 32'hFFFF_FFF9, 32'h8000_0000};
        db  = '{32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF};
        for (int i = 0; i < 10; i++) begin
            logic [4:0] op;
            logic [31:0] a, b;
            if (i < 4) begin
                op = dop[i]; a = da[i]; b = db[i];
            end else begin
                op = (i % 2 == 0) ? 5'b10010 : 5'b10011;
                a = $urandom;
                b = $urandom >> $urandom_range(0, 30);
            end
            @(negedge CLK);
            md_issue(op, a, b);
            md_wait(c, dn);
            e = ref_md(op, a, b);
            n_cmp++;
            if (c != 34 || dn !== 1'b1 || {HI, LO} !== e) begin
                n_fail++;
                $display("FAIL div[%0d] op=%b a=%h b=%h: cyc=%0d hi=%h lo=%h, required 34 hi=%h lo=%h", i, op, a, b, c, HI, LO, e[63:32], e[31:0]);
            end
        end
`else
        logic [31:0] hi0, lo0;
        @(negedge CLK);
        md_issue(5'b11000, 32'h0BAD_CAFE, 32'h0);
        md_issue(5'b11001, 32'h1357_9BDF, 32'h0);
        hi0 = 32'h0BAD_CAFE;
        lo0 = 32'h1357_9BDF;
        md_issue(5'b10010, 32'hFFFF_FFF9, 32'h2);
        md_wait(c, dn);
        dn = 1'b0;
        repeat (40) begin
            if (DONE === 1'b1) dn = 1'b1;
            @(negedge CLK);
        end
        n_cmp++;
        if (c != 0 || dn !== 1'b0 || HI !== hi0 || LO !== lo0) begin
            n_fail++;
            $display("FAIL div_disabled: busy_cyc=%0d done_seen=%b hi=%h lo=%h, required 0 0 %h %h", c, dn, HI, LO, hi0, lo0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int c;
        logic dn;
        @(negedge CLK);
        md_issue(5'b11000, 32'hA5, 32'h0);
        n_cmp++;
        if (HI !== 32'hA5 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: hi=%h done=%b busy=%b, required 000000a5 0 0", HI, DONE, BUSY);
        end
        md_issue(5'b10000, 32'hFFFF_FFFD, 32'h7);
        md_wait(c, dn);
        n_cmp++;
        if (c != 34 || dn !== 1'b1 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL b2b_first: cyc=%0d done=%b hi=%h lo=%h, required 34 1 ffffffff ffffffeb", c, dn, HI, LO);
        end
        // Second START lands in the DONE cycle
        md_issue(5'b10000, 32'h0001_0000, 32'h0003_0000);
        md_wait(c, dn);
        n_cmp++;
        if (c != 34 || dn !== 1'b1 || HI !== 32'h3 || LO !== 32'h0) begin
            n_fail++;
            $display("FAIL b2b_second: cyc=%0d done=%b hi=%h lo=%h, required 34 1 00000003 00000000", c, dn, HI, LO);
        end
    endtask

    task automatic test_busy_rst();
        logic [31:0] hi0;
        int dcnt;
        @(negedge CLK);
        hi0 = HI;
        md_issue(5'b10000, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (3) @(negedge CLK);
        md_issue(5'b11000, 32'hDEAD, 32'h0);
        n_cmp++;
        if (HI !== hi0 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mthi_ignored: hi=%h busy=%b, required %h 1", HI, BUSY, hi0);
        end
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_abort: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", BUSY, DONE, HI, LO);
        end
        dcnt = 0;
        repeat (45) begin
            if (DONE === 1'b1 || BUSY === 1'b1) dcnt++;
            @(negedge CLK);
        end
        n_cmp++;
        if (dcnt != 0 || HI !== 32'h0 || LO !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_no_done: done/busy cycles=%0d hi=%h lo=%h, required 0 0 0", dcnt, HI, LO);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_mult();
        test_div();
        test_back_to_back();
        test_busy_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
